clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//   Multi-channel programmable clock divider. Each of NCH channels emits a
//   near-50% square wave (clk_out) and a one-cycle period-start strobe (tick).
//   Each channel's divisor is written at run time through a ready/enable port.
//   A new divisor takes effect only at that channel's period boundary, so
//   outputs never glitch. Sits at top level and feeds LED blink, scan and
//   baud timing from the single system clock.
// PARAMETERS
//   NCH       4        number of channels (1..16)
//   DW        20       divisor/counter width, bits
//   DIV_RESET 1000000  divisor loaded into every channel at reset (< 2**DW)
//   CW        derived  channel-index width = max(1, clog2(NCH)); localparam
// PORTS
//   clk      in   1      system clock, all logic on posedge
//   rst      in   1      reset, synchronous, active-low
//   wr_en    in   1      divisor write request
//   wr_ch    in   CW     target channel of write
//   wr_div   in   DW     new divisor; 0 = channel disabled
//   wr_ready out  1      comb: 1 = write to wr_ch would be accepted
//   pending  out  NCH    per-channel: shadow divisor waiting for boundary
//   tick     out  NCH    registered one-cycle pulse at start of each period
//   clk_out  out  NCH    registered divided clock
// BEHAVIOUR
//   Per channel state: cnt[DW], div_a (active), div_s (shadow), pending.
//   Reset (rst==0 at posedge): cnt=0, div_a=DIV_RESET, div_s=0, pending=0,
//     tick=0, clk_out=0. Reset mid-period aborts it; shadow is discarded.
//   Accept: wr_en && wr_ch<NCH && !pending[wr_ch] -> div_s<=wr_div, pending<=1.
//   wr_ready = (wr_ch>=NCH) | !pending[wr_ch]. Out-of-range writes are dropped.
//   Writes to a pending channel are dropped; the first value is kept.
//   boundary = (div_a==0) | (cnt==div_a-1).
//   Each cycle, div_a==0: cnt<=0, tick<=0, clk_out<=0.
//   Each cycle, div_a!=0: tick<=(cnt==0); clk_out<=(cnt<((div_a+1)>>1));
//     cnt<=boundary ? 0 : cnt+1.
//   Output latency: outputs reflect cnt one cycle later. The first tick and
//     clk_out rise occur on the 1st posedge after rst goes high.
//   Period = div_a cycles exactly. High phase = ceil(div_a/2) cycles;
//     low phase = floor(div_a/2) cycles.
//   div_a=1 -> clk_out constant 1, tick every cycle.
//   div_a=2 -> 1 high / 1 low.
//   At boundary && pending (registered before this cycle): div_a<=div_s,
//     pending<=0, cnt<=0. New period starts next cycle.
//   Write accepted in the same cycle as a boundary: applied at the NEXT
//     boundary, not the current one.
//   Disabled channel (div_a==0) is at a boundary every cycle, so a write
//     applies 2 cycles after acceptance.
//   Counter arithmetic is DW-bit unsigned. The cnt==div_a-1 compare never
//     wraps because div_a!=0 in that branch.
//   Channels are fully independent; writes touch only wr_ch.
// CONFIGURATION
//   CLK_DIV_SYNC_EN defined: adds input sync (1 bit, after wr_div).
//     sync==1 at posedge: every channel is forced to boundary.
//     Pending shadows are applied and cnt<=0.
//     All enabled channels tick together on the following cycle.
//     A write accepted in the same cycle is held pending (not applied).
//   CLK_DIV_SYNC_EN undefined: no sync port; channels free-run, phases
//     set by reset and write history only.
// TESTING
//   1 DIV_RESET=10, NCH=4, release rst at cycle 0 -> all tick at cycles
//     1,11,21; clk_out 5 high/5 low, all channels in phase.
//   2 write ch1 div=5 at cycle 4 -> pending[1]=1, wr_ready(ch1)=0 until the
//     cycle-10 boundary; ch1 ticks at 11,16,21; 3 high/2 low; pending clears.
//   3 write ch2 div=0, then div=3 -> ch2 clk_out/tick held 0;
//     3-cycle period (2 high/1 low) starts 2 cycles after the second write.
//   4 div=1 and div=2 on ch0/ch3 -> ch0 clk_out stuck 1, tick every cycle;
//     ch3 toggles every cycle, tick every 2nd cycle.
//   5 NCH=3: write wr_ch=3 -> dropped, wr_ready=1. Second write to a pending
//     channel -> dropped. rst mid-period -> state back to reset values.
//   6 CLK_DIV_SYNC_EN: ch0 div=4, ch1 div=7 out of phase; pulse sync ->
//     both tick on the next cycle, then every 4 and 7 cycles respectively.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor updates at
// each channel's period boundary. Optional CLK_DIV_SYNC_EN adds a global re-phase input.

module clk_div_ch #(
  parameter int DW        = 20,
  parameter int DIV_RESET = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_acc,
  input  logic [DW-1:0] i_div,
  input  logic          i_sync,
  output logic          o_pend,
  output logic          o_tick,
  output logic          o_clk
);
  logic [DW-1:0] r_cnt, r_div_a, r_div_s;
  logic          r_pend, r_tick, r_clk;
  logic          w_en, w_bnd;
  logic [DW:0]   w_half;

  assign w_en   = (r_div_a != '0);
  // a disabled channel sits on a boundary every cycle so a new divisor lands quickly
  assign w_bnd  = !w_en || (r_cnt == r_div_a - 1'b1) || i_sync;
  assign w_half = ({1'b0, r_div_a} + 1'b1) >> 1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_div_a <= DW'(DIV_RESET);
      r_div_s <= '0;
      r_pend  <= 1'b0;
      r_tick  <= 1'b0;
      r_clk   <= 1'b0;
    end else begin
      if (w_en) begin
        r_tick <= (r_cnt == '0);
        r_clk  <= ({1'b0, r_cnt} < w_half);
        r_cnt  <= w_bnd ? '0 : r_cnt + 1'b1;
      end else begin
        r_tick <= 1'b0;
        r_clk  <= 1'b0;
        r_cnt  <= '0;
      end
      // only a shadow registered before this cycle may be applied
      if (w_bnd && r_pend) begin
        r_div_a <= r_div_s;
        r_pend  <= 1'b0;
        r_cnt   <= '0;
      end else if (i_acc && !r_pend) begin
        r_div_s <= i_div;
        r_pend  <= 1'b1;
      end
    end
  end

  assign o_pend = r_pend;
  assign o_tick = r_tick;
  assign o_clk  = r_clk;
endmodule

module clk_div_multi #(
  parameter  int NCH       = 4,
  parameter  int DW        = 20,
  parameter  int DIV_RESET = 1000000,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [CW-1:0]  wr_ch,
  input  logic [DW-1:0]  wr_div,
`ifdef CLK_DIV_SYNC_EN
  input  logic           sync,
`endif
  output logic           wr_ready,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] clk_out
);
  logic [(1<<CW)-1:0] w_pend_pad;
  logic               w_sync;

`ifdef CLK_DIV_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  // out-of-range channels read as not pending, so they report ready
  always_comb begin
    w_pend_pad          = '0;
    w_pend_pad[NCH-1:0] = pending;
  end
  assign wr_ready = !w_pend_pad[wr_ch];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic w_acc;
    assign w_acc = wr_en && (wr_ch == CW'(g)) && !pending[g];
    clk_div_ch #(.DW(DW), .DIV_RESET(DIV_RESET)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_acc  (w_acc),
      .i_div  (wr_div),
      .i_sync (w_sync),
      .o_pend (pending[g]),
      .o_tick (tick[g]),
      .o_clk  (clk_out[g])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed vector table, corner sequences,
// and random traffic against a period-start-time reference model.

module tb_clk_div_multi;
  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int DR  = 10;
  localparam int CW  = 2;
`ifdef CLK_DIV_SYNC_EN
  localparam bit HAS_SYNC = 1'b1;
`else
  localparam bit HAS_SYNC = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, wr_en;
  logic [CW-1:0]  wr_ch;
  logic [DW-1:0]  wr_div;
`ifdef CLK_DIV_SYNC_EN
  logic           sync;
`endif
  logic           wr_ready;
  logic [NCH-1:0] pending, tick, clk_out;

  clk_div_multi #(.NCH(NCH), .DW(DW), .DIV_RESET(DR)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_div   (wr_div),
`ifdef CLK_DIV_SYNC_EN
    .sync     (sync),
`endif
    .wr_ready (wr_ready),
    .pending  (pending),
    .tick     (tick),
    .clk_out  (clk_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int n = 0;
  // model: active divisor, shadow, pending flag, edge index of current period's tick
  int m_d[NCH], m_sh[NCH], m_start[NCH];
  bit m_pend[NCH];

  typedef struct {
    logic           r, we;
    logic [CW-1:0]  ch;
    logic [DW-1:0]  dv;
    logic [NCH-1:0] t, c, p;
  } vec_t;
  vec_t tbl[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [CW-1:0] ch,
                      input logic [DW-1:0] dv, input logic sy);
    logic [NCH-1:0] e_t, e_c, e_p;
    logic e_rdy;
    bit   s, bnd, acc;
    int   age;
    rst = r; wr_en = we; wr_ch = ch; wr_div = dv;
`ifdef CLK_DIV_SYNC_EN
    sync = sy;
`endif
    s = HAS_SYNC && sy;
    e_rdy = 1'b1;
    if (int'(ch) < NCH) e_rdy = !m_pend[ch];
    #1 chk("wr_ready", {31'd0, wr_ready}, {31'd0, e_rdy});
    @(posedge clk);
    n++;
    for (int i = 0; i < NCH; i++) begin
      if (!r) begin
        e_t[i] = 1'b0; e_c[i] = 1'b0;
        m_d[i] = DR; m_sh[i] = 0; m_pend[i] = 1'b0; m_start[i] = n + 1;
      end else begin
        age    = n - m_start[i];
        e_t[i] = (m_d[i] != 0) && (age == 0);
        e_c[i] = (m_d[i] != 0) && (2 * age < m_d[i]);
        bnd    = (m_d[i] == 0) || (age == m_d[i] - 1) || s;
        acc    = we && (int'(ch) == i) && !m_pend[i];
        if (bnd) begin
          m_start[i] = n + 1;
          if (m_pend[i]) begin m_d[i] = m_sh[i]; m_pend[i] = 1'b0; end
        end
        if (acc) begin m_sh[i] = int'(dv); m_pend[i] = 1'b1; end
      end
      e_p[i] = m_pend[i];
    end
    #1;
    chk("tick",    {29'd0, tick},    {29'd0, e_t});
    chk("clk_out", {29'd0, clk_out}, {29'd0, e_c});
    chk("pending", {29'd0, pending}, {29'd0, e_p});
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int cnt;
    logic prev;
    logic [1:0] ex;
    // row = inputs for one edge and outputs seen right after it; row 0 is the reset edge
    tbl[0]  = '{1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 3'b000};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b111, 3'b000};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b111, 3'b000};
    tbl[4]  = '{1'b1, 1'b1, 2'd1, 8'd5, 3'b000, 3'b111, 3'b010};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b111, 3'b010};
    for (int i = 6; i <= 9; i++)
      tbl[i] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b010};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 3'b000};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b111, 3'b000};
    tbl[13] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b111, 3'b000};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b101, 3'b000};
    tbl[15] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b101, 3'b000};
    tbl[16] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b010, 3'b010, 3'b000};
    tbl[17] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b010, 3'b000};
    tbl[18] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b010, 3'b000};
    tbl[19] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    tbl[20] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    tbl[21] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 3'b000};

    rst = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
`ifdef CLK_DIV_SYNC_EN
    sync = 1'b0;
`endif
    for (int i = 0; i < NCH; i++) begin m_pend[i] = 1'b0; m_d[i] = DR; m_sh[i] = 0; m_start[i] = 0; end
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].r, tbl[i].we, tbl[i].ch, tbl[i].dv, 1'b0);
      chk($sformatf("tbl%0d_tick", i), {29'd0, tick},    {29'd0, tbl[i].t});
      chk($sformatf("tbl%0d_clk", i),  {29'd0, clk_out}, {29'd0, tbl[i].c});
      chk($sformatf("tbl%0d_pend", i), {29'd0, pending}, {29'd0, tbl[i].p});
    end

    // ch2 disabled, then restarted with a 3-cycle period
    step(1'b1, 1'b1, 2'd2, 8'd0, 1'b0);
    idle(10);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("dis_out", {30'd0, tick[2], clk_out[2]}, 32'd0);
      chk("dis_pend", {31'd0, pending[2]}, 32'd0);
    end
    step(1'b1, 1'b1, 2'd2, 8'd3, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      case (k)
        2, 5:    ex = 2'b11;
        3:       ex = 2'b01;
        default: ex = 2'b00;
      endcase
      chk($sformatf("div3_k%0d", k), {30'd0, tick[2], clk_out[2]}, {30'd0, ex});
    end

    // div=1 on ch0, div=2 on ch1
    step(1'b1, 1'b1, 2'd0, 8'd1, 1'b0);
    step(1'b1, 1'b1, 2'd1, 8'd2, 1'b0);
    idle(15);
    for (int i = 0; i < 6; i++) begin
      prev = clk_out[1];
      idle(1);
      chk("d1_clk",  {31'd0, clk_out[0]}, 32'd1);
      chk("d1_tick", {31'd0, tick[0]},    32'd1);
      chk("d2_clk",  {31'd0, clk_out[1]}, {31'd0, !prev});
      chk("d2_tick", {31'd0, tick[1]},    {31'd0, !prev});
    end

    // out-of-range write dropped
    rst = 1'b1; wr_en = 1'b1; wr_ch = 2'd3; wr_div = 8'd5;
    #1 chk("oor_ready", {31'd0, wr_ready}, 32'd1);
    step(1'b1, 1'b1, 2'd3, 8'd5, 1'b0);
    chk("oor_pend", {29'd0, pending}, 32'd0);

    // second write to a pending channel dropped; first divisor kept
    step(1'b1, 1'b1, 2'd0, 8'd7, 1'b0);
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd4;
    #1 chk("dup_ready", {31'd0, wr_ready}, 32'd0);
    step(1'b1, 1'b1, 2'd0, 8'd4, 1'b0);
    idle(4);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      idle(1);
      cnt += int'(tick[0]);
    end
    chk("dup_kept_ticks", cnt, 32'd2);

    // reset mid-period discards a pending shadow
    step(1'b1, 1'b1, 2'd1, 8'd3, 1'b0);
    step(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    chk("rst_pend", {29'd0, pending}, 32'd0);
    chk("rst_out",  {26'd0, tick, clk_out}, 32'd0);
    idle(1);
    chk("post_rst_tick", {29'd0, tick}, 32'd7);

`ifdef CLK_DIV_SYNC_EN
    step(1'b1, 1'b1, 2'd0, 8'd4, 1'b0);
    step(1'b1, 1'b1, 2'd1, 8'd7, 1'b0);
    idle(12);
    step(1'b1, 1'b1, 2'd2, 8'd5, 1'b1);
    chk("sync_hold_pend", {31'd0, pending[2]}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      case (k)
        1:       ex = 2'b11;
        5:       ex = 2'b01;
        8:       ex = 2'b10;
        default: ex = 2'b00;
      endcase
      chk($sformatf("sync_k%0d", k), {30'd0, tick[1:0]}, {30'd0, ex});
    end
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0),
           CW'($urandom_range(0, 3)), DW'($urandom_range(0, 12)),
           ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
